seq_onehot_decoder: RTL and testbench
=====================================

# seq_onehot_decoder

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready load port and an optional auto-scan mode that walks the active output across all lines at a programmable dwell rate. It generalises the team's combinational 3-to-8 decoder for sequential uses such as chip-select generation, LED/row scanning and round-robin enable strobes. It sits between a control FSM or CPU register and the decoded enable lines.

## Interface
- SEL_W, 3, select width; output width OUT_W = 2**SEL_W (derived, not overridable)
- DWELL_W, 8, width of the dwell-period input and internal dwell counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  load request
- in_ready  out  1  load accepted when in_valid && in_ready at a rising edge
- in_sel  in  SEL_W  index to decode
- in_en  in  1  1: drive one-hot of in_sel; 0: drive all-zero (index still stored)
- scan_start  in  1  level-sampled request to begin scanning
- scan_stop  in  1  level-sampled request to end scanning
- dwell  in  DWELL_W  cycles per scan step; 0 treated as 1
- out  out  OUT_W  registered decoded output
- out_idx  out  SEL_W  stored index
- out_vld  out  1  registered; 1 when any bit of out is set
- scan_busy  out  1  1 while in SCAN state
- scan_wrap  out  1  one-cycle pulse when out_idx wraps OUT_W-1 -> 0 during scan

## Operation
- States: IDLE (after reset), HOLD (value loaded or scan stopped), SCAN.
- in_ready = 1 in IDLE/HOLD, 0 in SCAN; in_valid during SCAN is ignored (not queued).
- Load (IDLE/HOLD, in_valid=1): out_idx <= in_sel; out <= in_en ? (1 << in_sel) : 0; state -> HOLD.
- Scan start (IDLE/HOLD, scan_start=1, scan_stop=0): state -> SCAN; dwell latched as D = max(dwell,1); dwell counter <= D-1; out forced to 1 << out_idx regardless of in_en.
- Load and scan_start on same edge: load applied, scan starts from the new in_sel.
- In SCAN: counter decrements each cycle; at 0, out_idx <= (out_idx+1) mod OUT_W, out rotates left by 1, counter reloads D-1. dwell changes mid-scan have no effect.
- Wrap: advance from OUT_W-1 to 0 sets scan_wrap for exactly the following cycle.
- Scan stop (SCAN, scan_stop=1): state -> HOLD; out/out_idx frozen at current value; an advance due on that same edge is suppressed; scan_wrap not asserted.
- scan_start and scan_stop both high: stop wins (no scan begins; SCAN exits).
- out is always one-hot or all-zero; never multi-hot.

## Timing
- Reset (async assert, any state): out=0, out_idx=0, out_vld=0, scan_busy=0, scan_wrap=0, in_ready=1, state IDLE, counter=0. Deassertion sampled synchronously; first load accepted on first rising edge with rst_n high.
- Load latency: 1 cycle (out valid the cycle after the accepting edge).
- Scan: start accepted at edge t0 -> scan_busy=1 and out = 1<<out_idx from t0; advances at edges t0+D, t0+2D, ...
- scan_wrap rises with the edge that sets out_idx=0 and falls on the next edge.
- Stop at edge ts -> scan_busy=0 and in_ready=1 after ts.
- No combinational path from any input to any output.

## Configuration
- DEC_SCAN_EN defined: full behaviour above.
- DEC_SCAN_EN undefined: SCAN state, dwell counter and rotate logic removed; scan_start, scan_stop, dwell ignored; scan_busy and scan_wrap tied 0; in_ready tied 1; only IDLE/HOLD load behaviour remains.

## Test plan
- Reset then load in_sel=0..7, in_en=1 (SEL_W=3) -> out = 8'h01, 02, 04, ... 80 one cycle after each accept; out_vld=1.
- Load in_sel=5, in_en=0 -> out=8'h00, out_idx=5, out_vld=0; then scan_start, dwell=2 -> out=8'h20, then 40, 80, 01 every 2 cycles; scan_wrap one cycle with out=8'h01.
- dwell=0 scan from idx 7 -> advances every cycle; wrap pulse after first step; in_valid with in_sel=3 during scan -> in_ready=0, out unaffected.
- scan_stop coincident with a due advance at out=8'h04 -> out stays 8'h04, scan_busy=0 next cycle; scan_start+scan_stop together from HOLD -> no scan.
- Assert rst_n=0 mid-scan between edges -> out=0, scan_busy=0, scan_wrap=0 immediately; out_vld=0.
- SEL_W=4 build without DEC_SCAN_EN: load in_sel=15 -> out=16'h8000; scan_start pulses -> scan_busy stays 0, in_ready stays 1.

Source files
------------

// File: rtl/seq_onehot_decoder_if.sv
// Load/scan control and decoded-output bundle for seq_onehot_decoder.
// master drives load and scan requests; slave is the decoder.
interface seq_onehot_decoder_if #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
);
    localparam int OUT_W = 2 ** SEL_W;

    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   in_sel;
    logic               in_en;
    logic               scan_start;
    logic               scan_stop;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   out;
    logic [SEL_W-1:0]   out_idx;
    logic               out_vld;
    logic               scan_busy;
    logic               scan_wrap;

    modport master (
        output in_valid, in_sel, in_en, scan_start, scan_stop, dwell,
        input  in_ready, out, out_idx, out_vld, scan_busy, scan_wrap
    );

    modport slave (
        input  in_valid, in_sel, in_en, scan_start, scan_stop, dwell,
        output in_ready, out, out_idx, out_vld, scan_busy, scan_wrap
    );
endinterface

// File: rtl/seq_onehot_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with optional auto-scan (macro DEC_SCAN_EN).
// Latency: 1 cycle from accepted load or scan start to out; scan steps every max(dwell,1) cycles.
// Backpressure: in_ready low only while scanning; loads offered then are dropped, not queued.
module seq_onehot_decoder #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    seq_onehot_decoder_if.slave  dif
);
    localparam int OUT_W = 2 ** SEL_W;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] idx);
        return {{(OUT_W-1){1'b0}}, 1'b1} << idx;
    endfunction

`ifdef DEC_SCAN_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_SCAN = 2'd2} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;
`endif

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             vld_q, vld_d;

`ifdef DEC_SCAN_EN
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] rld_q, rld_d;
    logic               wrap_q, wrap_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        wrap_d  = 1'b0;
        if (state_q == ST_SCAN) begin
            // Stop takes priority over any advance due on the same edge.
            if (dif.scan_stop) begin
                state_d = ST_HOLD;
            end else if (cnt_q == '0) begin
                idx_d  = idx_q + 1'b1;
                out_d  = {out_q[OUT_W-2:0], out_q[OUT_W-1]};
                cnt_d  = rld_q;
                wrap_d = &idx_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else begin
            if (dif.in_valid) begin
                idx_d   = dif.in_sel;
                out_d   = dif.in_en ? onehot(dif.in_sel) : '0;
                state_d = ST_HOLD;
            end
            if (dif.scan_start && !dif.scan_stop) begin
                state_d = ST_SCAN;
                out_d   = onehot(idx_d);
                rld_d   = (dif.dwell == '0) ? '0 : dif.dwell - 1'b1;
                cnt_d   = rld_d;
            end
        end
        vld_d = |out_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            rld_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rld_q  <= rld_d;
            wrap_q <= wrap_d;
        end
    end

    assign dif.scan_busy = (state_q == ST_SCAN);
    assign dif.in_ready  = (state_q != ST_SCAN);
    assign dif.scan_wrap = wrap_q;
`else
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        out_d   = out_q;
        if (dif.in_valid) begin
            idx_d   = dif.in_sel;
            out_d   = dif.in_en ? onehot(dif.in_sel) : '0;
            state_d = ST_HOLD;
        end
        vld_d = |out_d;
    end

    assign dif.scan_busy = 1'b0;
    assign dif.in_ready  = 1'b1;
    assign dif.scan_wrap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    assign dif.out     = out_q;
    assign dif.out_idx = idx_q;
    assign dif.out_vld = vld_q;
endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Directed bench for seq_onehot_decoder: cycle model plus literal checkpoints, both scan builds.
module tb_seq_onehot_decoder;
`ifdef DEC_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif
    localparam int OUT_W = 8;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    seq_onehot_decoder_if #(.SEL_W(3), .DWELL_W(8)) dif ();
    seq_onehot_decoder_if #(.SEL_W(4), .DWELL_W(8)) dif4 ();

    seq_onehot_decoder #(.SEL_W(3), .DWELL_W(8)) dut (.clk(clk), .rst_n(rst_n), .dif(dif));
    seq_onehot_decoder #(.SEL_W(4), .DWELL_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .dif(dif4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Behavioural model: which line is lit, whether lit, and how far into the current dwell step.
    int m_idx, m_on, m_scan, m_D, m_t, m_wrap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idx = 0; m_on = 0; m_scan = 0; m_D = 1; m_t = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            if (m_scan != 0) begin
                if (dif.scan_stop) begin
                    m_scan = 0;
                end else begin
                    m_t = m_t + 1;
                    if (m_t == m_D) begin
                        m_t    = 0;
                        m_wrap = (m_idx == OUT_W - 1) ? 1 : 0;
                        m_idx  = (m_idx + 1) % OUT_W;
                    end
                end
            end else begin
                if (dif.in_valid) begin
                    m_idx = int'(dif.in_sel);
                    m_on  = dif.in_en ? 1 : 0;
                end
                if (SCAN && dif.scan_start && !dif.scan_stop) begin
                    m_scan = 1;
                    m_on   = 1;
                    m_D    = (dif.dwell == 0) ? 1 : int'(dif.dwell);
                    m_t    = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_out",  32'(dif.out),       (m_on != 0) ? (32'd1 << m_idx) : 32'd0);
        chk("m_idx",  32'(dif.out_idx),   32'(m_idx));
        chk("m_vld",  32'(dif.out_vld),   32'(m_on));
        chk("m_busy", 32'(dif.scan_busy), 32'(m_scan));
        chk("m_rdy",  32'(dif.in_ready),  (m_scan != 0) ? 32'd0 : 32'd1);
        chk("m_wrap", 32'(dif.scan_wrap), 32'(m_wrap));
    end

    logic [7:0] tbl [8];

    initial begin
        tbl[0] = 8'h01; tbl[1] = 8'h02; tbl[2] = 8'h04; tbl[3] = 8'h08;
        tbl[4] = 8'h10; tbl[5] = 8'h20; tbl[6] = 8'h40; tbl[7] = 8'h80;
        rst_n = 1'b0;
        dif.in_valid = 0; dif.in_sel = '0; dif.in_en = 0;
        dif.scan_start = 0; dif.scan_stop = 0; dif.dwell = '0;
        dif4.in_valid = 0; dif4.in_sel = '0; dif4.in_en = 0;
        dif4.scan_start = 0; dif4.scan_stop = 0; dif4.dwell = '0;
        tick();
        tick();
        chk("rst_out", 32'(dif.out), 32'h0);
        chk("rst_vld", 32'(dif.out_vld), 32'h0);
        chk("rst_rdy", 32'(dif.in_ready), 32'h1);
        chk("rst_busy", 32'(dif.scan_busy), 32'h0);
        rst_n = 1'b1;

        // Back-to-back loads of every index.
        for (int k = 0; k < 8; k++) begin
            dif.in_valid = 1; dif.in_sel = 3'(k); dif.in_en = 1;
            tick();
            chk("load_out", 32'(dif.out), 32'(tbl[k]));
            chk("load_vld", 32'(dif.out_vld), 32'h1);
        end
        dif.in_sel = 3'd5; dif.in_en = 0;
        tick();
        dif.in_valid = 0;
        chk("dis_out", 32'(dif.out), 32'h0);
        chk("dis_idx", 32'(dif.out_idx), 32'd5);
        chk("dis_vld", 32'(dif.out_vld), 32'h0);

        // Scan from idx 5 at dwell 2; dwell change mid-scan must not matter.
        dif.scan_start = 1; dif.dwell = 8'd2;
        tick();
        dif.scan_start = 0; dif.dwell = 8'd5;
        chk("scan0", 32'(dif.out), SCAN ? 32'h20 : 32'h00);
        chk("scan0_busy", 32'(dif.scan_busy), 32'(SCAN));
        tick(); tick();
        chk("scan1", 32'(dif.out), SCAN ? 32'h40 : 32'h00);
        tick(); tick();
        chk("scan2", 32'(dif.out), SCAN ? 32'h80 : 32'h00);
        tick(); tick();
        chk("scan3", 32'(dif.out), SCAN ? 32'h01 : 32'h00);
        chk("wrap_hi", 32'(dif.scan_wrap), 32'(SCAN));
        tick();
        chk("wrap_lo", 32'(dif.scan_wrap), 32'h0);
        tick();
        chk("scan4", 32'(dif.out), SCAN ? 32'h02 : 32'h00);
        tick(); tick();
        chk("scan5", 32'(dif.out), SCAN ? 32'h04 : 32'h00);
        tick();
        dif.scan_stop = 1;
        tick();
        dif.scan_stop = 0;
        chk("stop_out", 32'(dif.out), SCAN ? 32'h04 : 32'h00);
        chk("stop_busy", 32'(dif.scan_busy), 32'h0);
        chk("stop_rdy", 32'(dif.in_ready), 32'h1);

        // Start and stop together: no scan begins.
        dif.scan_start = 1; dif.scan_stop = 1; dif.dwell = 8'd1;
        tick();
        dif.scan_start = 0; dif.scan_stop = 0;
        tick(); tick();
        chk("both_busy", 32'(dif.scan_busy), 32'h0);
        chk("both_out", 32'(dif.out), SCAN ? 32'h04 : 32'h00);

        // Load idx 7 with scan start at dwell 0; a load offered mid-scan is dropped.
        dif.in_valid = 1; dif.in_sel = 3'd7; dif.in_en = 1;
        dif.scan_start = 1; dif.dwell = 8'd0;
        tick();
        dif.scan_start = 0; dif.in_sel = 3'd3;
        chk("d0_out", 32'(dif.out), 32'h80);
        tick();
        chk("d0_step", 32'(dif.out), SCAN ? 32'h01 : 32'h08);
        chk("d0_wrap", 32'(dif.scan_wrap), 32'(SCAN));
        chk("d0_rdy", 32'(dif.in_ready), SCAN ? 32'h0 : 32'h1);
        tick();
        dif.in_valid = 0;
        chk("d0_next", 32'(dif.out), SCAN ? 32'h02 : 32'h08);
        for (int k = 0; k < 7; k++) tick();
        chk("d0_wrap2", 32'(dif.scan_wrap), 32'(SCAN));

        // Asynchronous reset between edges.
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(dif.out), 32'h0);
        chk("arst_busy", 32'(dif.scan_busy), 32'h0);
        chk("arst_wrap", 32'(dif.scan_wrap), 32'h0);
        chk("arst_vld", 32'(dif.out_vld), 32'h0);
        chk("arst_rdy", 32'(dif.in_ready), 32'h1);
        tick();
        rst_n = 1'b1;
        dif.in_valid = 1; dif.in_sel = 3'd6; dif.in_en = 1;
        tick();
        dif.in_valid = 0;
        chk("post_rst", 32'(dif.out), 32'h40);

        // Wide instance: top line, then a scan request.
        dif4.in_valid = 1; dif4.in_sel = 4'd15; dif4.in_en = 1;
        tick();
        dif4.in_valid = 0;
        chk("w_out", 32'(dif4.out), 32'h8000);
        chk("w_vld", 32'(dif4.out_vld), 32'h1);
        dif4.scan_start = 1; dif4.dwell = 8'd3;
        tick();
        dif4.scan_start = 0;
        chk("w_busy", 32'(dif4.scan_busy), 32'(SCAN));
        chk("w_rdy", 32'(dif4.in_ready), SCAN ? 32'h0 : 32'h1);
        chk("w_hold", 32'(dif4.out), 32'h8000);
        dif4.scan_stop = 1;
        tick();
        dif4.scan_stop = 0;
        chk("w_stop", 32'(dif4.scan_busy), 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
